// File: rtl/pll_supervisor_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
// Also used by the clock-generator wrappers that embed it.
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLL_RESET,
    S_WAIT_LOCK,
    S_STABILISE,
    S_RELEASE,
    S_RUNNING,
    S_FAILED
  } state_t;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2flop.sv
// Two-stage synchroniser for a single asynchronous level.
// Resets to 0 so a freshly reset design never sees a stale 1.
module sync_2flop (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up and recovery: reset pulse, lock wait with retry,
// stability check, then staggered release of domain resets.
module pll_lock_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int NUM_DOMAINS    = 4,
  parameter int RESET_CYCLES   = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES = 8,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   pll_locked,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_reset_n,
  output logic                   running,
  output logic                   failed,
  output logic [3:0]             retry_count,
  output logic [7:0]             lock_loss_count
);

  localparam int LAST = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int CW = cnt_width(RESET_CYCLES, LOCK_TIMEOUT,
                                STABLE_CYCLES, LAST + 1);

  typedef logic [CW-1:0] cnt_t;

  state_t                   state, state_d;
  cnt_t                     cnt, cnt_d, cnt_inc;
  logic [NUM_DOMAINS-1:0]   mask_d;
  logic [3:0]               retry_d, retry_inc;
  logic [7:0]               loss_d;
  logic                     locked_s;

  sync_2flop u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (locked_s)
  );

  // Domains whose release slot coincides with counter value c
  function automatic logic [NUM_DOMAINS-1:0] hit(input cnt_t c);
    logic [NUM_DOMAINS-1:0] h;
    h = '0;
    for (int i = 0; i < NUM_DOMAINS; i++)
      if (32'(c) == i * STAGGER_CYCLES) h[i] = 1'b1;
    return h;
  endfunction

  assign cnt_inc   = cnt + CW'(1);
  assign retry_inc = retry_count + 4'd1;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    mask_d  = domain_reset_n;
    retry_d = retry_count;
    loss_d  = lock_loss_count;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      mask_d  = '0;
      retry_d = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state_d = S_PLL_RESET;
          cnt_d   = '0;
        end
        S_PLL_RESET: begin
          if (cnt == CW'(RESET_CYCLES - 1)) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = S_STABILISE;
            cnt_d   = '0;
          end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = (retry_inc == 4'(MAX_RETRIES)) ?
                      S_FAILED : S_PLL_RESET;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_STABILISE: begin
          if (!locked_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
            cnt_d  = '0;
            mask_d = hit('0);
            if (LAST == 0) begin
              state_d = S_RUNNING;
              retry_d = '0;
            end else begin
              state_d = S_RELEASE;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_RELEASE, S_RUNNING: begin
          if (!locked_s) begin
            state_d = S_PLL_RESET;
            cnt_d   = '0;
            mask_d  = '0;
            if (lock_loss_count != 8'hff)
              loss_d = lock_loss_count + 8'd1;
          end else if (state == S_RELEASE) begin
            cnt_d  = cnt_inc;
            mask_d = domain_reset_n | hit(cnt_inc);
            if (32'(cnt_inc) == LAST) begin
              state_d = S_RUNNING;
              retry_d = '0;
            end
          end
        end
        S_FAILED: state_d = S_FAILED;
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          mask_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      pll_rst         <= 1'b1;
      domain_reset_n  <= '0;
      running         <= 1'b0;
      failed          <= 1'b0;
      retry_count     <= '0;
      lock_loss_count <= '0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      pll_rst         <= state_d inside {S_IDLE, S_PLL_RESET, S_FAILED};
      domain_reset_n  <= mask_d;
      running         <= (state_d == S_RUNNING);
      failed          <= (state_d == S_FAILED);
      retry_count     <= retry_d;
      lock_loss_count <= loss_d;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: timed vector tables with a
// queue of expected output snapshots checked between edges.
module tb_pll_lock_supervisor;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       pll_locked;
  logic       pll_rst;
  logic [3:0] domain_reset_n;
  logic       running;
  logic       failed;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [95:0] tag;
    int          n;
    logic        en;
    logic        lk;
    logic        prst;
    logic [3:0]  dom;
    logic        run;
    logic        fail;
    logic [3:0]  rt;
    logic [7:0]  ls;
  } vec_t;

  vec_t tbl[$];
  vec_t rtbl[$];
  vec_t exp_q[$];

  pll_lock_supervisor #(
    .NUM_DOMAINS    (4),
    .RESET_CYCLES   (16),
    .LOCK_TIMEOUT   (48),
    .STABLE_CYCLES  (16),
    .STAGGER_CYCLES (8),
    .MAX_RETRIES    (3)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .pll_locked      (pll_locked),
    .pll_rst         (pll_rst),
    .domain_reset_n  (domain_reset_n),
    .running         (running),
    .failed          (failed),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [95:0] tag,
    input int          n,
    input logic        en,
    input logic        lk,
    input logic        prst,
    input logic [3:0]  dom,
    input logic        run,
    input logic        fail,
    input logic [3:0]  rt,
    input logic [7:0]  ls
  );
    vec_t v;
    v.tag = tag; v.n = n; v.en = en; v.lk = lk;
    v.prst = prst; v.dom = dom; v.run = run;
    v.fail = fail; v.rt = rt; v.ls = ls;
    return v;
  endfunction

  task automatic check(input vec_t e);
    total++;
    if (pll_rst !== e.prst || domain_reset_n !== e.dom ||
        running !== e.run || failed !== e.fail ||
        retry_count !== e.rt || lock_loss_count !== e.ls) begin
      bad++;
      $display("FAIL %0s: got rst=%b dom=%b run=%b fail=%b rt=%0d loss=%0d want rst=%b dom=%b run=%b fail=%b rt=%0d loss=%0d",
               e.tag, pll_rst, domain_reset_n, running, failed,
               retry_count, lock_loss_count, e.prst, e.dom,
               e.run, e.fail, e.rt, e.ls);
    end
  endtask

  task automatic apply(input vec_t v);
    enable     = v.en;
    pll_locked = v.lk;
    exp_q.push_back(v);
    repeat (v.n) @(negedge clk);
    check(exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Bring-up, lock loss in RUNNING, STABILISE glitch,
    // lock loss mid-RELEASE, then disable
    tbl.push_back(mk("idle",      2,1'b0,1'b0,1'b1,4'h0,1'b0,1'b0,4'd0,8'd0));
    tbl.push_back(mk("prst_hi",  16,1'b1,1'b0,1'b1,4'h0,1'b0,1'b0,4'd0,8'd0));
    tbl.push_back(mk("prst_lo",   1,1'b1,1'b0,1'b0,4'h0,1'b0,1'b0,4'd0,8'd0));
    tbl.push_back(mk("wait_lock",40,1'b1,1'b0,1'b0,4'h0,1'b0,1'b0,4'd0,8'd0));
    tbl.push_back(mk("pre_rel0", 18,1'b1,1'b1,1'b0,4'h0,1'b0,1'b0,4'd0,8'd0));
    tbl.push_back(mk("rel0",      1,1'b1,1'b1,1'b0,4'h1,1'b0,1'b0,4'd0,8'd0));
    tbl.push_back(mk("pre_rel1",  7,1'b1,1'b1,1'b0,4'h1,1'b0,1'b0,4'd0,8'd0));
    tbl.push_back(mk("rel1",      1,1'b1,1'b1,1'b0,4'h3,1'b0,1'b0,4'd0,8'd0));
    tbl.push_back(mk("rel2",      8,1'b1,1'b1,1'b0,4'h7,1'b0,1'b0,4'd0,8'd0));
    tbl.push_back(mk("pre_run",   7,1'b1,1'b1,1'b0,4'h7,1'b0,1'b0,4'd0,8'd0));
    tbl.push_back(mk("run",       1,1'b1,1'b1,1'b0,4'hf,1'b1,1'b0,4'd0,8'd0));
    tbl.push_back(mk("hold",     10,1'b1,1'b1,1'b0,4'hf,1'b1,1'b0,4'd0,8'd0));
    tbl.push_back(mk("loss_sync", 2,1'b1,1'b0,1'b0,4'hf,1'b1,1'b0,4'd0,8'd0));
    tbl.push_back(mk("loss_clr",  1,1'b1,1'b0,1'b1,4'h0,1'b0,1'b0,4'd0,8'd1));
    tbl.push_back(mk("rst_pulse",15,1'b1,1'b0,1'b1,4'h0,1'b0,1'b0,4'd0,8'd1));
    tbl.push_back(mk("rst_end",   1,1'b1,1'b0,1'b0,4'h0,1'b0,1'b0,4'd0,8'd1));
    tbl.push_back(mk("stab_10",  13,1'b1,1'b1,1'b0,4'h0,1'b0,1'b0,4'd0,8'd1));
    tbl.push_back(mk("glitch",    1,1'b1,1'b0,1'b0,4'h0,1'b0,1'b0,4'd0,8'd1));
    tbl.push_back(mk("nominal",   5,1'b1,1'b1,1'b0,4'h0,1'b0,1'b0,4'd0,8'd1));
    tbl.push_back(mk("pre_rel0b",13,1'b1,1'b1,1'b0,4'h0,1'b0,1'b0,4'd0,8'd1));
    tbl.push_back(mk("rel0b",     1,1'b1,1'b1,1'b0,4'h1,1'b0,1'b0,4'd0,8'd1));
    tbl.push_back(mk("run_b",    24,1'b1,1'b1,1'b0,4'hf,1'b1,1'b0,4'd0,8'd1));
    tbl.push_back(mk("drop_b",    3,1'b1,1'b0,1'b1,4'h0,1'b0,1'b0,4'd0,8'd2));
    tbl.push_back(mk("rst_b",    16,1'b1,1'b0,1'b0,4'h0,1'b0,1'b0,4'd0,8'd2));
    tbl.push_back(mk("mid_rel",  27,1'b1,1'b1,1'b0,4'h3,1'b0,1'b0,4'd0,8'd2));
    tbl.push_back(mk("mid_sync",  2,1'b1,1'b0,1'b0,4'h3,1'b0,1'b0,4'd0,8'd2));
    tbl.push_back(mk("mid_clr",   1,1'b1,1'b0,1'b1,4'h0,1'b0,1'b0,4'd0,8'd3));
    tbl.push_back(mk("rst_c",    16,1'b1,1'b0,1'b0,4'h0,1'b0,1'b0,4'd0,8'd3));
    tbl.push_back(mk("pre_rel0c",18,1'b1,1'b1,1'b0,4'h0,1'b0,1'b0,4'd0,8'd3));
    tbl.push_back(mk("rel0c",     1,1'b1,1'b1,1'b0,4'h1,1'b0,1'b0,4'd0,8'd3));
    tbl.push_back(mk("disable",   1,1'b0,1'b0,1'b1,4'h0,1'b0,1'b0,4'd0,8'd3));

    // Lock never arrives: three timeouts, FAILED, then disable
    rtbl.push_back(mk("r_en",    16,1'b1,1'b0,1'b1,4'h0,1'b0,1'b0,4'd0,8'd3));
    rtbl.push_back(mk("r_fall",   1,1'b1,1'b0,1'b0,4'h0,1'b0,1'b0,4'd0,8'd3));
    rtbl.push_back(mk("r_pre1",  47,1'b1,1'b0,1'b0,4'h0,1'b0,1'b0,4'd0,8'd3));
    rtbl.push_back(mk("r_to1",    1,1'b1,1'b0,1'b1,4'h0,1'b0,1'b0,4'd1,8'd3));
    rtbl.push_back(mk("r_pulse", 15,1'b1,1'b0,1'b1,4'h0,1'b0,1'b0,4'd1,8'd3));
    rtbl.push_back(mk("r_fall2",  1,1'b1,1'b0,1'b0,4'h0,1'b0,1'b0,4'd1,8'd3));
    rtbl.push_back(mk("r_to2",   48,1'b1,1'b0,1'b1,4'h0,1'b0,1'b0,4'd2,8'd3));
    rtbl.push_back(mk("r_pre3",  63,1'b1,1'b0,1'b0,4'h0,1'b0,1'b0,4'd2,8'd3));
    rtbl.push_back(mk("r_fail",   1,1'b1,1'b0,1'b1,4'h0,1'b0,1'b1,4'd3,8'd3));
    rtbl.push_back(mk("r_sticky",20,1'b1,1'b0,1'b1,4'h0,1'b0,1'b1,4'd3,8'd3));
    rtbl.push_back(mk("r_clear",  1,1'b0,1'b0,1'b1,4'h0,1'b0,1'b0,4'd0,8'd3));

    reset_n    = 1'b0;
    enable     = 1'b0;
    pll_locked = 1'b0;
    @(negedge clk);
    exp_q.push_back(mk("reset",0,1'b0,1'b0,1'b1,4'h0,1'b0,1'b0,4'd0,8'd0));
    check(exp_q.pop_front());
    reset_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);
    foreach (rtbl[i]) apply(rtbl[i]);

    // Bring up with lock already present, then async reset
    enable     = 1'b1;
    pll_locked = 1'b1;
    begin
      int k;
      k = 0;
      while (running !== 1'b1 && k < 200) begin
        @(negedge clk);
        k++;
      end
      total++;
      if (running !== 1'b1) begin
        bad++;
        $display("FAIL run_wait: got running=%b want 1", running);
      end
    end
    exp_q.push_back(mk("run_loss",0,1'b1,1'b1,1'b0,4'hf,1'b1,1'b0,4'd0,8'd3));
    check(exp_q.pop_front());
    @(negedge clk);
    #2 reset_n = 1'b0;
    exp_q.push_back(mk("async_rst",0,1'b1,1'b1,1'b1,4'h0,1'b0,1'b0,4'd0,8'd0));
    #1 check(exp_q.pop_front());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
